eth_phy_rx_ber_mon_multi: RTL and testbench

Multi-lane, parametrised 64b/66b sync-header BER monitor for the 10G/25G/40G PHY receive path. It sits after the per-lane gearboxes. Each lane's 2-bit sync header is checked against the valid encodings 01 and 10. A shared window timer drives per-lane high-BER flags using a configurable threshold. Each lane also keeps a saturating invalid-header statistics counter, and all lane flags are ORed into an aggregate status bit.

---
 rtl/eth_phy_rx_ber_mon_multi.sv | 109 ++++++++++
 tb/tb_eth_phy_rx_ber_mon_multi.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_phy_rx_ber_mon_multi.sv
// Multi-lane 64b/66b sync-header BER monitor. It uses a shared window timer, per-lane high-BER
// flags and saturating per-lane invalid-header statistics counters.
module eth_phy_rx_ber_mon_multi #(
  parameter int LANES         = 4,
  parameter int HDR_WIDTH     = 2,
  parameter int COUNT_125US   = 19531,
  parameter int BER_THRESH    = 16,
  parameter int ERR_CNT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [LANES*HDR_WIDTH-1:0]     serdes_rx_hdr,
  input  logic [LANES-1:0]               serdes_rx_hdr_valid,
  input  logic                           stat_clear,
  output logic [LANES-1:0]               rx_high_ber,
  output logic                           rx_high_ber_any,
  output logic [LANES*ERR_CNT_WIDTH-1:0] rx_err_count,
  output logic                           window_tick
);

  localparam int TW = $clog2(COUNT_125US);
  localparam int BW = $clog2(BER_THRESH + 1);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(COUNT_125US - 1);
  localparam logic [BW-1:0] THRESH       = BW'(BER_THRESH);
  localparam logic [BW-1:0] THRESH_M1    = BW'(BER_THRESH - 1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_ONE = ERR_CNT_WIDTH'(1);

  if (HDR_WIDTH != 2) begin : g_chk_hdr
    $error("HDR_WIDTH must be 2");
  end
  if (COUNT_125US < 2) begin : g_chk_cnt
    $error("COUNT_125US must be >= 2");
  end
  if ((BER_THRESH < 2) || (BER_THRESH > 255)) begin : g_chk_thr
    $error("BER_THRESH must be in 2..255");
  end

  logic [TW-1:0]    r_timer;
  logic             w_tick;
  logic [LANES-1:0] w_high_ber_nxt;
  logic             r_high_ber_any;

  assign w_tick = (r_timer == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer <= TIMER_RELOAD;
    end else if (w_tick) begin
      r_timer <= TIMER_RELOAD;
    end else begin
      r_timer <= r_timer - TW'(1);
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [1:0]               w_hdr;
    logic                     w_err;
    logic                     w_set;
    logic [BW-1:0]            r_ber_cnt;
    logic                     r_hit;
    logic                     r_high_ber;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

    assign w_hdr = serdes_rx_hdr[i*HDR_WIDTH +: 2];
    assign w_err = serdes_rx_hdr_valid[i] & ((w_hdr == 2'b00) | (w_hdr == 2'b11));
    assign w_set = w_err & (r_ber_cnt == THRESH_M1);
    // At window end, only a threshold hit inside the closing window keeps the flag.
    assign w_high_ber_nxt[i] = w_tick ? (r_hit | w_set) : (r_high_ber | w_set);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_ber_cnt  <= '0;
        r_hit      <= 1'b0;
        r_high_ber <= 1'b0;
      end else begin
        r_high_ber <= w_high_ber_nxt[i];
        if (w_tick) begin
          r_ber_cnt <= '0;
          r_hit     <= 1'b0;
        end else begin
          if (w_err && (r_ber_cnt != THRESH)) r_ber_cnt <= r_ber_cnt + BW'(1);
          if (w_set) r_hit <= 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_err_cnt <= '0;
      end else if (stat_clear) begin
        r_err_cnt <= w_err ? ERR_ONE : '0;
      end else if (w_err && !(&r_err_cnt)) begin
        r_err_cnt <= r_err_cnt + ERR_ONE;
      end
    end

    assign rx_high_ber[i] = r_high_ber;
    assign rx_err_count[i*ERR_CNT_WIDTH +: ERR_CNT_WIDTH] = r_err_cnt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_high_ber_any <= 1'b0;
    else        r_high_ber_any <= |w_high_ber_nxt;
  end

  assign rx_high_ber_any = r_high_ber_any;
  assign window_tick     = w_tick;

endmodule

// File: tb/tb_eth_phy_rx_ber_mon_multi.sv
// Directed bench for eth_phy_rx_ber_mon_multi with a 100-cycle window and a threshold of 16.
// A second instance uses 4-bit statistics counters so that saturation can be checked.
module tb_eth_phy_rx_ber_mon_multi;
  logic            clk, rst_n, stat_clear;
  logic [3:0][1:0] hdr;
  logic [3:0]      valid;
  logic [3:0]      flag, flag4;
  logic            any, any4, tick, tick4;
  logic [31:0]     cnt;
  logic [15:0]     cnt4;
  int total = 0, bad = 0, cyc = 0;

  eth_phy_rx_ber_mon_multi #(.LANES(4), .HDR_WIDTH(2), .COUNT_125US(100), .BER_THRESH(16),
    .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .serdes_rx_hdr(hdr), .serdes_rx_hdr_valid(valid),
    .stat_clear(stat_clear), .rx_high_ber(flag), .rx_high_ber_any(any),
    .rx_err_count(cnt), .window_tick(tick));

  eth_phy_rx_ber_mon_multi #(.LANES(4), .HDR_WIDTH(2), .COUNT_125US(100), .BER_THRESH(16),
    .ERR_CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .serdes_rx_hdr(hdr), .serdes_rx_hdr_valid(valid),
    .stat_clear(stat_clear), .rx_high_ber(flag4), .rx_high_ber_any(any4),
    .rx_err_count(cnt4), .window_tick(tick4));

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic next_cyc();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 0; hdr = {4{2'b01}}; valid = 4'hF; stat_clear = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    cyc = 0;
  endtask

  task automatic test_reset();
    rst_n = 1; hdr = {4{2'b01}}; valid = 4'hF; stat_clear = 0;
    #3 rst_n = 0;
    #1;
    total++; if (flag !== 4'b0 || any !== 1'b0) begin bad++; $display("FAIL reset_flags: flag=%b any=%b want 0000/0", flag, any); end
    total++; if (cnt !== 32'h0 || cnt4 !== 16'h0) begin bad++; $display("FAIL reset_counts: cnt=%h cnt4=%h want 0", cnt, cnt4); end
    total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick: got %b want 0", tick); end
  endtask

  task automatic test_clean();
    int tick_bad = 0, ticks = 0, flag_bad = 0;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      if (tick !== ((cyc % 100) == 99)) tick_bad++;
      if (tick === 1'b1) ticks++;
      if (flag !== 4'b0 || any !== 1'b0) flag_bad++;
      next_cyc();
    end
    total++; if (tick_bad !== 0) begin bad++; $display("FAIL clean_tick_pos: %0d misplaced ticks want 0", tick_bad); end
    total++; if (ticks !== 3) begin bad++; $display("FAIL clean_tick_cnt: got %0d want 3", ticks); end
    total++; if (flag_bad !== 0) begin bad++; $display("FAIL clean_flags: %0d cycles flagged want 0", flag_bad); end
    total++; if (cnt !== 32'h0) begin bad++; $display("FAIL clean_counts: got %h want 0", cnt); end
  endtask

  task automatic test_lane2();
    do_reset();
    for (int c = 0; c <= 200; c++) begin
      hdr[2] = (cyc >= 10 && cyc <= 25) ? 2'b11 : 2'b01;
      if (cyc == 25) begin
        total++; if (flag[2] !== 1'b0) begin bad++; $display("FAIL lane2_early: got %b want 0", flag[2]); end
      end
      if (cyc == 26) begin
        total++; if (flag !== 4'b0100 || any !== 1'b1) begin bad++; $display("FAIL lane2_set: flag=%b any=%b want 0100/1", flag, any); end
      end
      if (cyc == 30) begin
        total++; if (cnt !== 32'h0010_0000) begin bad++; $display("FAIL lane2_count: got %h want 00100000", cnt); end
      end
      if (cyc == 100 || cyc == 199) begin
        total++; if (flag[2] !== 1'b1) begin bad++; $display("FAIL lane2_hold@%0d: got %b want 1", cyc, flag[2]); end
      end
      if (cyc == 200) begin
        total++; if (flag !== 4'b0 || any !== 1'b0) begin bad++; $display("FAIL lane2_clear: flag=%b any=%b want 0000/0", flag, any); end
      end
      next_cyc();
    end
    hdr[2] = 2'b01;
  endtask

  task automatic test_below();
    logic seen = 1'b0;
    do_reset();
    for (int c = 0; c <= 300; c++) begin
      hdr[0] = (cyc < 300 && (cyc % 100) >= 10 && (cyc % 100) <= 24) ? 2'b00 : 2'b01;
      if (flag[0] === 1'b1) seen = 1'b1;
      next_cyc();
    end
    hdr[0] = 2'b01;
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL below_flag: asserted, want never"); end
    total++; if (cnt[7:0] !== 8'd45) begin bad++; $display("FAIL below_count: got %0d want 45", cnt[7:0]); end
  endtask

  task automatic test_valid_gate();
    do_reset();
    for (int c = 0; c <= 200; c++) begin
      if (cyc >= 10 && cyc <= 25) begin hdr[1] = 2'b00; valid[1] = 1'b0; end
      else if ((cyc >= 80 && cyc <= 94) || cyc == 99) begin hdr[1] = 2'b00; valid[1] = 1'b1; end
      else begin hdr[1] = 2'b01; valid[1] = 1'b1; end
      if (cyc == 30) begin
        total++; if (flag[1] !== 1'b0 || cnt[15:8] !== 8'd0) begin bad++; $display("FAIL gate_ignored: flag=%b cnt=%0d want 0/0", flag[1], cnt[15:8]); end
      end
      if (cyc == 99) begin
        total++; if (flag[1] !== 1'b0 || tick !== 1'b1) begin bad++; $display("FAIL gate_pre: flag=%b tick=%b want 0/1", flag[1], tick); end
      end
      if (cyc == 100) begin
        total++; if (flag[1] !== 1'b1 || cnt[15:8] !== 8'd16) begin bad++; $display("FAIL gate_tick_set: flag=%b cnt=%0d want 1/16", flag[1], cnt[15:8]); end
      end
      if (cyc == 199) begin
        total++; if (flag[1] !== 1'b1) begin bad++; $display("FAIL gate_hold: got %b want 1", flag[1]); end
      end
      if (cyc == 200) begin
        total++; if (flag[1] !== 1'b0) begin bad++; $display("FAIL gate_clear: got %b want 0", flag[1]); end
      end
      next_cyc();
    end
    hdr[1] = 2'b01; valid[1] = 1'b1;
  endtask

  task automatic test_multi();
    do_reset();
    for (int c = 0; c <= 30; c++) begin
      hdr[0] = (cyc >= 10 && cyc <= 25) ? 2'b11 : 2'b01;
      hdr[3] = (cyc >= 10 && cyc <= 25) ? 2'b00 : 2'b10;
      hdr[1] = (cyc >= 10 && cyc <= 17) ? 2'b11 : 2'b10;
      if (cyc == 26) begin
        total++; if (flag !== 4'b1001 || any !== 1'b1) begin bad++; $display("FAIL multi_flags: flag=%b any=%b want 1001/1", flag, any); end
      end
      if (cyc == 30) begin
        total++; if (cnt !== 32'h1000_0810) begin bad++; $display("FAIL multi_counts: got %h want 10000810", cnt); end
      end
      next_cyc();
    end
    hdr = {4{2'b01}};
  endtask

  task automatic test_sat();
    do_reset();
    for (int c = 0; c <= 52; c++) begin
      hdr[3] = ((cyc >= 10 && cyc <= 29) || cyc == 40) ? 2'b11 : 2'b01;
      stat_clear = (cyc == 40 || cyc == 50);
      if (cyc == 30) begin
        total++; if (cnt4[15:12] !== 4'd15 || cnt[31:24] !== 8'd20) begin bad++; $display("FAIL sat_count: w4=%0d w8=%0d want 15/20", cnt4[15:12], cnt[31:24]); end
      end
      if (cyc == 41) begin
        total++; if (cnt4[15:12] !== 4'd1 || cnt[31:24] !== 8'd1) begin bad++; $display("FAIL sat_clear_err: w4=%0d w8=%0d want 1/1", cnt4[15:12], cnt[31:24]); end
      end
      if (cyc == 51) begin
        total++; if (cnt4[15:12] !== 4'd0) begin bad++; $display("FAIL sat_clear: got %0d want 0", cnt4[15:12]); end
        total++; if (flag4[3] !== 1'b1 || flag[3] !== 1'b1 || any4 !== 1'b1) begin bad++; $display("FAIL sat_flag_kept: flag4=%b flag=%b any4=%b want 1/1/1", flag4[3], flag[3], any4); end
      end
      next_cyc();
    end
    hdr[3] = 2'b01; stat_clear = 0;
  endtask

  task automatic test_reset_mid();
    int first = -1;
    do_reset();
    for (int c = 0; c < 50; c++) begin
      hdr[2] = (cyc >= 10 && cyc <= 25) ? 2'b11 : 2'b01;
      next_cyc();
    end
    hdr[2] = 2'b01;
    total++; if (flag[2] !== 1'b1) begin bad++; $display("FAIL mid_pre: got %b want 1", flag[2]); end
    rst_n = 0;
    #1;
    total++; if (flag !== 4'b0 || any !== 1'b0 || cnt !== 32'h0 || tick !== 1'b0) begin bad++; $display("FAIL mid_async: flag=%b any=%b cnt=%h tick=%b want 0", flag, any, cnt, tick); end
    repeat (3) @(negedge clk);
    rst_n = 1;
    cyc = 0;
    for (int c = 0; c < 200; c++) begin
      if (first < 0 && tick === 1'b1) first = cyc;
      if (first < 0) next_cyc();
    end
    total++; if (first !== 99) begin bad++; $display("FAIL mid_first_tick: got %0d want 99", first); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_lane2();
    test_below();
    test_valid_gate();
    test_multi();
    test_sat();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
